// File: rtl/jtframe_dly_ram_pkg.sv
// Shared helpers for the run-time adjustable block-RAM delay line.
package jtframe_dly_ram_pkg;

    // Effective delay: a request of 0 behaves as 1, and nothing exceeds the buffer depth.
    function automatic int unsigned clamp_dly(input int unsigned dly, input int unsigned dmax);
        if (dly == 0)   return 1;
        if (dly > dmax) return dmax;
        return dly;
    endfunction

endpackage

// File: rtl/jtframe_dly_bram.sv
// Simple dual-port RAM: one write port and one registered read port on the same clock.
module jtframe_dly_bram #(
    parameter int W  = 5,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/jtframe_dly_ram.sv
// Block-RAM delay line whose depth (in clk_en ticks) is chosen at run time by dly.
// dout is zero until the line has primed for the current delay; stale RAM is never shown.
module jtframe_dly_ram
    import jtframe_dly_ram_pkg::*;
#(
    parameter int W  = 5,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic [AW-1:0] dly,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          primed
);

    localparam int unsigned DMAX = (1 << AW) - 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] fill;
    logic [AW-1:0] dly_l;
    logic          warm;
    logic [AW-1:0] d;
    logic [AW-1:0] rd_addr;
    logic          we;
    logic [W-1:0]  ram_q;
    logic [W-1:0]  byp_q;
    logic          byp_sel;
    logic [W-1:0]  src;
    logic [AW:0]   fill_inc;
    logic [AW-1:0] fill_nx;
    logic          primed_nx;
    logic          data_ok;

    assign d  = AW'(clamp_dly(32'(dly), DMAX));
    assign we = clk_en & ~rst;

    // On a tick, fetch for the following tick using the delay being latched now; while
    // idle, keep fetching for the pending tick with the held delay.
    assign rd_addr = clk_en ? (wr_ptr + AW'(1) - d) : (wr_ptr - dly_l);

    jtframe_dly_bram #(.W(W), .AW(AW)) u_bram (
        .clk     (clk),
        .we      (we),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Reading the slot being written is served from din, so RAM read-during-write mode is irrelevant.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_q   <= '0;
            byp_sel <= 1'b0;
        end else begin
            byp_q   <= din;
            byp_sel <= we && (rd_addr == wr_ptr);
        end
    end

    assign src       = byp_sel ? byp_q : ram_q;
    assign fill_inc  = {1'b0, fill} + 1'b1;
    assign fill_nx   = (fill_inc > {1'b0, dly_l}) ? dly_l : fill_inc[AW-1:0];
    assign primed_nx = fill_inc >= {1'b0, dly_l};
    // After reset the slot read on the priming tick predates the first write; after a
    // delay change the changing tick itself wrote that slot, so it is real data.
    assign data_ok   = primed_nx && (warm || (fill >= dly_l));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            fill   <= '0;
            dly_l  <= d;
            dout   <= '0;
            primed <= 1'b0;
            warm   <= 1'b0;
        end else if (clk_en) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (d != dly_l) begin
                dly_l  <= d;
                fill   <= '0;
                primed <= 1'b0;
                dout   <= '0;
                warm   <= 1'b1;
            end else begin
                fill   <= fill_nx;
                primed <= primed_nx;
                dout   <= data_ok ? src : '0;
            end
        end
    end

endmodule
